// File: rtl/acia_rx_if.sv
// Host-side register interface of the ACIA receiver: parity configuration,
// the read strobe and the received character with its status flags.
interface acia_rx_if;
    logic       R_PME;
    logic [1:0] R_PMC;
    logic       RXREAD;
    logic [7:0] RXDATA;
    logic       RXFULL;
    logic       PERR;
    logic       FERR;
    logic       OVRN;

    modport master (
        output R_PME, R_PMC, RXREAD,
        input  RXDATA, RXFULL, PERR, FERR, OVRN
    );

    modport slave (
        input  R_PME, R_PMC, RXREAD,
        output RXDATA, RXFULL, PERR, FERR, OVRN
    );
endinterface

// File: rtl/acia_rx.sv
// ACIA serial receiver, 16x oversampled on BCLK, optional parity, one stop bit.
// Define ACIA_RX_MAJORITY_EN for a 2-of-3 vote over ticks 7/8/9 per bit.
module acia_rx (
    input  logic      BCLK,
    input  logic      RESET,
    input  logic      RX,
    acia_rx_if.slave  host
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t     state;
    logic       rx_meta;
    logic       rxs;
    logic [3:0] tick;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_err;
    logic       exp_par;
    logic       sample_now;
    logic       sample_bit;

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge BCLK or posedge RESET) begin
        if (RESET) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
        end
    end

`ifdef ACIA_RX_MAJORITY_EN
    localparam logic [3:0] SAMPLE_TICK = 4'd9;
    logic s7;
    logic s8;

    always_ff @(posedge BCLK or posedge RESET) begin
        if (RESET) begin
            s7 <= 1'b1;
            s8 <= 1'b1;
        end else begin
            if (tick == 4'd7) s7 <= rxs;
            if (tick == 4'd8) s8 <= rxs;
        end
    end

    assign sample_bit = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
`else
    localparam logic [3:0] SAMPLE_TICK = 4'd8;
    assign sample_bit = rxs;
`endif

    assign sample_now = (tick == SAMPLE_TICK);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        exp_par = 1'b0;
        case (host.R_PMC)
            2'b00:   exp_par = ~^shreg;
            2'b01:   exp_par = ^shreg;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    always_ff @(posedge BCLK or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            tick        <= 4'd0;
            bit_cnt     <= 3'd0;
            shreg       <= 8'h00;
            par_err     <= 1'b0;
            host.RXDATA <= 8'h00;
            host.RXFULL <= 1'b0;
            host.PERR   <= 1'b0;
            host.FERR   <= 1'b0;
            host.OVRN   <= 1'b0;
        end else begin
            if (host.RXREAD && host.RXFULL) begin
                host.RXFULL <= 1'b0;
                host.OVRN   <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    tick    <= 4'd0;
                    bit_cnt <= 3'd0;
                    par_err <= 1'b0;
                    if (!rxs) state <= ST_START;
                end

                ST_START: begin
                    tick <= tick + 4'd1;
                    if (sample_now && sample_bit) begin
                        state <= ST_IDLE;
                        tick  <= 4'd0;
                    end else if (tick == 4'd15) begin
                        state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    tick <= tick + 4'd1;
                    if (sample_now) shreg <= {sample_bit, shreg[7:1]};
                    if (tick == 4'd15) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
                            state   <= host.R_PME ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                ST_PARITY: begin
                    tick <= tick + 4'd1;
                    if (sample_now) par_err <= (sample_bit != exp_par);
                    if (tick == 4'd15) state <= ST_STOP;
                end

                ST_STOP: begin
                    tick <= tick + 4'd1;
                    if (sample_now) begin
                        tick  <= 4'd0;
                        state <= sample_bit ? ST_IDLE : ST_BREAK;
                        // A completing character wins over the read-clear above.
                        if (!host.RXFULL || host.RXREAD) begin
                            host.RXDATA <= shreg;
                            host.PERR   <= par_err & host.R_PME;
                            host.FERR   <= ~sample_bit;
                            host.RXFULL <= 1'b1;
                            host.OVRN   <= 1'b0;
                        end else begin
                            host.OVRN   <= 1'b1;
                        end
                    end
                end

                ST_BREAK: begin
                    tick <= 4'd0;
                    if (rxs) state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    tick  <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acia_rx.sv
// Scoreboard bench for acia_rx: stimulus pushes expected characters, a monitor
// pops and compares whenever RXFULL or OVRN rises.
module tb_acia_rx;

    logic BCLK  = 1'b0;
    logic RESET = 1'b1;
    logic RX    = 1'b1;

    acia_rx_if host ();

    acia_rx dut (
        .BCLK  (BCLK),
        .RESET (RESET),
        .RX    (RX),
        .host  (host)
    );

    always #5 BCLK = ~BCLK;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovrn;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam int ST_IDLE_ENC  = 0;
    localparam int ST_BREAK_ENC = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_tick(input logic v);
        @(negedge BCLK);
        RX = v;
    endtask

    // One character: start, 8 data LSB first, optional parity, one stop.
    // glitch_bit selects a data bit that gets a one-tick low pulse mid-bit.
    task automatic send_char(input logic [7:0] data, input logic pme,
                             input logic par_bit, input int glitch_bit);
        for (int t = 0; t < 16; t++) drive_tick(1'b0);
        for (int b = 0; b < 8; b++)
            for (int t = 0; t < 16; t++)
                drive_tick((glitch_bit == b && t == 9) ? 1'b0 : data[b]);
        if (pme)
            for (int t = 0; t < 16; t++) drive_tick(par_bit);
        for (int t = 0; t < 16; t++) drive_tick(1'b1);
    endtask

    task automatic push(input logic [7:0] d, input logic p, input logic f, input logic o);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        e.ovrn = o;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        check(name, sb.size(), 0);
    endtask

    task automatic host_read();
        @(negedge BCLK);
        host.RXREAD = 1'b1;
        @(negedge BCLK);
        host.RXREAD = 1'b0;
        check("read_rxfull", {31'd0, host.RXFULL}, 0);
        check("read_ovrn",   {31'd0, host.OVRN},   0);
    endtask

    // Monitor: compares the character presented on every RXFULL/OVRN rise.
    initial begin : monitor
        logic prev_full;
        logic prev_ovrn;
        exp_t e;
        prev_full = 1'b0;
        prev_ovrn = 1'b0;
        forever begin
            @(negedge BCLK);
            if ((host.RXFULL && !prev_full) || (host.OVRN && !prev_ovrn)) begin
                check("sb_expected", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("mon_rxdata", {24'd0, host.RXDATA}, {24'd0, e.data});
                    check("mon_perr",   {31'd0, host.PERR},   {31'd0, e.perr});
                    check("mon_ferr",   {31'd0, host.FERR},   {31'd0, e.ferr});
                    check("mon_ovrn",   {31'd0, host.OVRN},   {31'd0, e.ovrn});
                    check("mon_rxfull", {31'd0, host.RXFULL}, 1);
                end
            end
            prev_full = host.RXFULL;
            prev_ovrn = host.OVRN;
        end
    end

    initial begin : stimulus
        host.R_PME  = 1'b0;
        host.R_PMC  = 2'b00;
        host.RXREAD = 1'b0;

        // Reset state
        repeat (4) @(negedge BCLK);
        check("rst_rxdata", {24'd0, host.RXDATA}, 0);
        check("rst_rxfull", {31'd0, host.RXFULL}, 0);
        check("rst_perr",   {31'd0, host.PERR},   0);
        check("rst_ferr",   {31'd0, host.FERR},   0);
        check("rst_ovrn",   {31'd0, host.OVRN},   0);
        check("rst_state",  32'(dut.state), ST_IDLE_ENC);
        RESET = 1'b0;
        repeat (20) drive_tick(1'b1);

        // 8N1 0x5A, no read yet
        push(8'h5A, 1'b0, 1'b0, 1'b0);
        send_char(8'h5A, 1'b0, 1'b0, -1);
        drain("drain_5a");
        check("hold_5a_full", {31'd0, host.RXFULL}, 1);
        host_read();

        // Parity: 0x07 has three ones
        host.R_PME = 1'b1;
        host.R_PMC = 2'b01;              // even: expect parity bit 1
        push(8'h07, 1'b1, 1'b0, 1'b0);
        send_char(8'h07, 1'b1, 1'b0, -1);
        drain("drain_even_bad");
        host_read();
        push(8'h07, 1'b0, 1'b0, 1'b0);
        send_char(8'h07, 1'b1, 1'b1, -1);
        drain("drain_even_ok");
        host_read();
        host.R_PMC = 2'b00;              // odd: expect parity bit 0
        push(8'h07, 1'b0, 1'b0, 1'b0);
        send_char(8'h07, 1'b1, 1'b0, -1);
        drain("drain_odd_ok");
        host_read();
        host.R_PMC = 2'b11;              // space: expect 0
        push(8'h07, 1'b1, 1'b0, 1'b0);
        send_char(8'h07, 1'b1, 1'b1, -1);
        drain("drain_space_bad");
        host_read();
        host.R_PMC = 2'b10;              // mark: expect 1
        push(8'h81, 1'b0, 1'b0, 1'b0);
        send_char(8'h81, 1'b1, 1'b1, -1);
        drain("drain_mark_ok");
        host_read();
        host.R_PME = 1'b0;
        host.R_PMC = 2'b00;

        // Overrun: 0x22 discarded while 0x11 unread
        push(8'h11, 1'b0, 1'b0, 1'b0);
        send_char(8'h11, 1'b0, 1'b0, -1);
        drain("drain_11");
        push(8'h11, 1'b0, 1'b0, 1'b1);
        send_char(8'h22, 1'b0, 1'b0, -1);
        drain("drain_ovrn");
        host_read();
        check("ovrn_hold_data", {24'd0, host.RXDATA}, 32'h11);

        // False start: 4 ticks low
        for (int t = 0; t < 4; t++) drive_tick(1'b0);
        for (int t = 0; t < 40; t++) drive_tick(1'b1);
        check("false_rxfull", {31'd0, host.RXFULL}, 0);
        check("false_state",  32'(dut.state), ST_IDLE_ENC);

        // Break: 20 bit times low
        push(8'h00, 1'b0, 1'b1, 1'b0);
        for (int t = 0; t < 320; t++) drive_tick(1'b0);
        drain("drain_break");
        check("break_state", 32'(dut.state), ST_BREAK_ENC);
        host_read();
        for (int t = 0; t < 32; t++) drive_tick(1'b1);
        check("break_exit_state", 32'(dut.state), ST_IDLE_ENC);
        push(8'h33, 1'b0, 1'b0, 1'b0);
        send_char(8'h33, 1'b0, 1'b0, -1);
        drain("drain_33");

        // Reset during data bit 4 of 0xA5
        for (int t = 0; t < 16; t++) drive_tick(1'b0);
        for (int b = 0; b < 4; b++)
            for (int t = 0; t < 16; t++) drive_tick(b[0] ? 1'b0 : 1'b1);
        for (int t = 0; t < 8; t++) drive_tick(1'b0);
        @(negedge BCLK);
        RESET = 1'b1;
        RX    = 1'b1;
        repeat (2) @(negedge BCLK);
        check("mrst_rxdata", {24'd0, host.RXDATA}, 0);
        check("mrst_rxfull", {31'd0, host.RXFULL}, 0);
        check("mrst_perr",   {31'd0, host.PERR},   0);
        check("mrst_ferr",   {31'd0, host.FERR},   0);
        check("mrst_ovrn",   {31'd0, host.OVRN},   0);
        check("mrst_state",  32'(dut.state), ST_IDLE_ENC);
        RESET = 1'b0;
        for (int t = 0; t < 16; t++) drive_tick(1'b1);
        push(8'hC3, 1'b0, 1'b0, 1'b0);
        send_char(8'hC3, 1'b0, 1'b0, -1);
        drain("drain_c3");
        host_read();

`ifdef ACIA_RX_MAJORITY_EN
        // One-tick glitch at the centre of data bit 3 is voted away
        push(8'hFF, 1'b0, 1'b0, 1'b0);
        send_char(8'hFF, 1'b0, 1'b0, 3);
        drain("drain_glitch_ff");
        host_read();
`endif

        for (int t = 0; t < 16; t++) drive_tick(1'b1);
        drain("sb_final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acia_rx.md
ACIA_RX -- requirements
Module: acia_rx

Interface
REQ-001 No parameters; all configuration is by ports and one macro.
REQ-002 BCLK  in  1  single clock, 16x baud rate; all logic on rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 RX  in  1  serial line, asynchronous to BCLK, idle high.
REQ-005 R_PME  in  1  parity enable; 1 means a parity bit follows data bit 7.
REQ-006 R_PMC  in  2  parity mode: 00 odd, 01 even, 10 mark, 11 space.
REQ-007 RXREAD  in  1  one-BCLK pulse, host consumed RXDATA.
REQ-008 RXDATA  out  8  last received character, LSB first on line.
REQ-009 RXFULL  out  1  RXDATA holds an unread character.
REQ-010 PERR  out  1  parity error for character in RXDATA.
REQ-011 FERR  out  1  framing error (stop bit sampled 0) for character in RXDATA.
REQ-012 OVRN  out  1  character completed while RXFULL=1 and was discarded.

Function
REQ-013 RX SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (RXS).
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK; tick counter 0..15 and bit counter 0..7.
REQ-015 IDLE: counter held 0; RXS=0 -> START next cycle.
REQ-016 START: at tick 8 the sampled bit is 1 -> IDLE (false start, nothing loaded); otherwise continue; tick 15 -> DATA, counter 0.
REQ-017 DATA: bit sampled at tick 8, shifted in at MSB (LSB-first order); tick 15 advances bit counter; after bit 7 -> PARITY if R_PME=1, else STOP.
REQ-018 PARITY: sampled at tick 8; expected = odd: ~XOR(data), even: XOR(data), mark: 1, space: 0; mismatch sets internal parity error; tick 15 -> STOP.
REQ-019 STOP: only the first stop bit is sampled, at tick 8; the character completes on that tick; sample 1 -> IDLE, sample 0 -> BREAK.
REQ-020 BREAK: waits for RXS=1, then -> IDLE; no start detection while in BREAK.
REQ-021 Completion with RXFULL=0, or with RXREAD=1 in the same cycle: RXDATA, PERR, FERR load on the next BCLK edge and RXFULL=1.
REQ-022 Completion with RXFULL=1 and RXREAD=0: RXDATA/PERR/FERR unchanged; OVRN=1.
REQ-023 RXREAD with no completion in the same cycle: RXFULL=0 and OVRN=0 next edge; RXDATA, PERR and FERR hold.
REQ-024 RXREAD while RXFULL=0: no effect.
REQ-025 PERR SHALL load 0 when R_PME=0.
REQ-026 R_PME/R_PMC SHALL be stable during a character; changing them mid-character gives undefined results for that character only.
REQ-027 Latency: RXFULL rises one BCLK after the stop-bit sample tick, i.e. about 9.5 bit times after the start edge (8N1), plus 2 cycles of synchronizer delay.

Reset
REQ-028 RESET=1: FSM to IDLE; counters 0; synchronizer flops 1; RXDATA=0x00; RXFULL, PERR, FERR and OVRN all 0.
REQ-029 Reset mid-character SHALL discard the partial character; after release, reception starts on the next falling edge of RXS.

Configuration
REQ-030 Macro ACIA_RX_MAJORITY_EN defined: each start, data, parity and stop sample is the majority of RXS at ticks 7, 8 and 9, decided at tick 9.
REQ-031 Macro undefined: single sample of RXS at tick 8; no other behaviour differs.

Verification
REQ-032 8N1 byte 0x5A, RXREAD never pulsed -> RXDATA=0x5A, RXFULL=1, PERR=0, FERR=0, OVRN=0.
REQ-033 R_PME=1, R_PMC=01, data 0x07, parity bit 0 sent -> RXDATA=0x07, PERR=1; same data with parity bit 1 -> PERR=0.
REQ-034 0x11 received, then 0x22 with no RXREAD -> RXDATA=0x11, OVRN=1; RXREAD pulse -> RXFULL=0, OVRN=0.
REQ-035 RX low for 4 ticks, then high -> no load, FSM back in IDLE; with ACIA_RX_MAJORITY_EN, a 1-tick low glitch on RX at tick 8 of a data bit of 0xFF -> RXDATA=0xFF.
REQ-036 RX held low for 20 bit times -> RXDATA=0x00, FERR=1, FSM in BREAK; RX high, then byte 0x33 -> RXDATA=0x33, FERR=0.
REQ-037 RESET asserted at data bit 4 of 0xA5 -> all outputs 0; next clean 0xC3 -> RXDATA=0xC3.
